// File: rtl/bayer_tpg.sv
// bayer_tpg: Bayer-mosaic test pattern generator producing raw sensor-style
// video for bring-up and regression, upstream of the debayer stage.
//
// Parameters:
//   PIXSIZE  pixel width in bits
//   ROW_W    row count width minus 1
//   COL_W    column count width minus 1
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   c_en             run enable (level); config latched only at frame boundaries
//   c_rows, c_cols   active geometry (LSB forced to 0, zero becomes 2)
//   c_hblank         blanking cycles between lines (0 treated as 1)
//   c_vblank         blanking cycles before each frame (0 treated as 1)
//   c_pattern        00 ramp, 01 flat colour, 10 moving diagonal, 11 checkerboard
//   c_bayer_mode     CFA phase for the flat-colour pattern
//   frame_valid_o    first pixel to last pixel of a frame, including inner HBLANK
//   line_valid_o     high on active pixels
//   pixel_data_o     pixel value, 0 outside active pixels
//   frame_start_o    one-cycle pulse on the first pixel of a frame
//   frame_cnt_o      completed-frame counter (wraps)
//
// State table:
//   state    | meaning
//   S_IDLE   | stopped, outputs low, waiting for c_en
//   S_VBLANK | vertical blanking before a frame
//   S_LINE   | emitting active pixels of one row
//   S_HBLANK | horizontal blanking between rows of a frame

module bayer_tpg #(
  parameter int PIXSIZE = 16,
  parameter int ROW_W   = 13,
  parameter int COL_W   = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               c_en,
  input  logic [ROW_W:0]     c_rows,
  input  logic [COL_W:0]     c_cols,
  input  logic [15:0]        c_hblank,
  input  logic [15:0]        c_vblank,
  input  logic [1:0]         c_pattern,
  input  logic [1:0]         c_bayer_mode,
  output logic               frame_valid_o,
  output logic               line_valid_o,
  output logic [PIXSIZE-1:0] pixel_data_o,
  output logic               frame_start_o,
  output logic [15:0]        frame_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_VBLANK, S_LINE, S_HBLANK} state_t;

  localparam logic [ROW_W:0]     ROW_ONE  = 1;
  localparam logic [ROW_W:0]     ROW_TWO  = 2;
  localparam logic [ROW_W:0]     ROW_MASK = ~ROW_ONE;
  localparam logic [COL_W:0]     COL_ONE  = 1;
  localparam logic [COL_W:0]     COL_TWO  = 2;
  localparam logic [COL_W:0]     COL_MASK = ~COL_ONE;
  localparam logic [PIXSIZE-1:0] PIX_ONES = '1;
  localparam logic [PIXSIZE-1:0] PIX_ZERO = '0;
  localparam logic [PIXSIZE-1:0] PIX_HALF = {1'b1, {(PIXSIZE-1){1'b0}}};

  state_t             state_q, state_d;
  logic [ROW_W:0]     rows_q, rows_d, row_q, row_d;
  logic [COL_W:0]     cols_q, cols_d, col_q, col_d;
  logic [15:0]        hblank_ld_q, hblank_ld_d;
  logic [15:0]        blank_q, blank_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic [1:0]         pattern_q, pattern_d;
  logic [1:0]         mode_q, mode_d;

  logic               frame_valid_q, frame_valid_d;
  logic               line_valid_q, line_valid_d;
  logic [PIXSIZE-1:0] pixel_q, pixel_d;
  logic               frame_start_q, frame_start_d;
  logic [15:0]        frame_cnt_out_q, frame_cnt_out_d;

  logic               latch_cfg;
  logic [ROW_W:0]     rows_even;
  logic [COL_W:0]     cols_even;
  logic [15:0]        vblank_ld;
  logic               last_col, last_row;
  logic [PIXSIZE-1:0] pix_pat;
  logic [1:0]         site, r_site, b_site;
  logic [31:0]        diag_sum;

  // Blank counters are loaded with max(n,1)-1 so the state lasts max(n,1) cycles.
  always_comb begin
    rows_even = c_rows & ROW_MASK;
    cols_even = c_cols & COL_MASK;
    vblank_ld = (c_vblank == 16'd0) ? 16'd0 : c_vblank - 16'd1;
    last_col  = (col_q == cols_q - COL_ONE);
    last_row  = (row_q == rows_q - ROW_ONE);
  end

  // Pattern value from the live row/col counters.
  always_comb begin
    site     = {row_q[0], col_q[0]};
    r_site   = 2'b11;
    b_site   = 2'b00;
    diag_sum = 32'(row_q) + 32'(col_q) + 32'(frame_cnt_q);
    pix_pat  = PIX_ZERO;
    case (mode_q)
      2'b00: begin b_site = 2'b00; r_site = 2'b11; end
      2'b01: begin b_site = 2'b01; r_site = 2'b10; end
      2'b10: begin r_site = 2'b00; b_site = 2'b11; end
      default: begin r_site = 2'b01; b_site = 2'b10; end
    endcase
    case (pattern_q)
      2'b00: pix_pat = PIXSIZE'(col_q);
      2'b01: begin
        if (site == r_site)      pix_pat = PIX_ONES;
        else if (site == b_site) pix_pat = PIX_ZERO;
        else                     pix_pat = PIX_HALF;
      end
      2'b10: pix_pat = PIXSIZE'(diag_sum);
      default: pix_pat = (row_q[3] ^ col_q[3]) ? PIX_ONES : PIX_ZERO;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    row_d       = row_q;
    col_d       = col_q;
    hblank_ld_d = hblank_ld_q;
    blank_d     = blank_q;
    frame_cnt_d = frame_cnt_q;
    pattern_d   = pattern_q;
    mode_d      = mode_q;
    latch_cfg   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (c_en) begin
          latch_cfg = 1'b1;
          blank_d   = vblank_ld;
          state_d   = S_VBLANK;
        end
      end
      S_VBLANK: begin
        if (blank_q == 16'd0) begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_LINE;
        end else begin
          blank_d = blank_q - 16'd1;
        end
      end
      S_LINE: begin
        if (!last_col) begin
          col_d = col_q + COL_ONE;
        end else if (!last_row) begin
          blank_d = hblank_ld_q;
          state_d = S_HBLANK;
        end else begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (c_en) begin
            latch_cfg = 1'b1;
            blank_d   = vblank_ld;
            state_d   = S_VBLANK;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        if (blank_q == 16'd0) begin
          row_d   = row_q + ROW_ONE;
          col_d   = '0;
          state_d = S_LINE;
        end else begin
          blank_d = blank_q - 16'd1;
        end
      end
    endcase

    // Zero geometry would break the 2x2 CFA tiling, so it falls back to 2.
    if (latch_cfg) begin
      rows_d      = (rows_even == '0) ? ROW_TWO : rows_even;
      cols_d      = (cols_even == '0) ? COL_TWO : cols_even;
      hblank_ld_d = (c_hblank == 16'd0) ? 16'd0 : c_hblank - 16'd1;
      pattern_d   = c_pattern;
      mode_d      = c_bayer_mode;
    end
  end

  // Outputs register the current state, so they trail the FSM by one cycle.
  always_comb begin
    frame_valid_d   = (state_q == S_LINE) || (state_q == S_HBLANK);
    line_valid_d    = (state_q == S_LINE);
    pixel_d         = (state_q == S_LINE) ? pix_pat : PIX_ZERO;
    frame_start_d   = (state_q == S_LINE) && (row_q == '0) && (col_q == '0);
    frame_cnt_out_d = frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rows_q          <= '0;
      cols_q          <= '0;
      row_q           <= '0;
      col_q           <= '0;
      hblank_ld_q     <= '0;
      blank_q         <= '0;
      frame_cnt_q     <= '0;
      pattern_q       <= '0;
      mode_q          <= '0;
      frame_valid_q   <= 1'b0;
      line_valid_q    <= 1'b0;
      pixel_q         <= '0;
      frame_start_q   <= 1'b0;
      frame_cnt_out_q <= '0;
    end else begin
      state_q         <= state_d;
      rows_q          <= rows_d;
      cols_q          <= cols_d;
      row_q           <= row_d;
      col_q           <= col_d;
      hblank_ld_q     <= hblank_ld_d;
      blank_q         <= blank_d;
      frame_cnt_q     <= frame_cnt_d;
      pattern_q       <= pattern_d;
      mode_q          <= mode_d;
      frame_valid_q   <= frame_valid_d;
      line_valid_q    <= line_valid_d;
      pixel_q         <= pixel_d;
      frame_start_q   <= frame_start_d;
      frame_cnt_out_q <= frame_cnt_out_d;
    end
  end

  assign frame_valid_o = frame_valid_q;
  assign line_valid_o  = line_valid_q;
  assign pixel_data_o  = pixel_q;
  assign frame_start_o = frame_start_q;
  assign frame_cnt_o   = frame_cnt_out_q;

endmodule
